// File: rtl/gsm_cmd_sequencer.sv
// Command issuer for the game state manager: captures player/button events, applies the
// game rules to the manager's state and issues one command at a time over flag/trig/done.
module gsm_cmd_sequencer #(
    parameter int         SETTLE_CYCLES  = 3,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [1:0] MAX_STAGE      = 2'd3
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic       hit_evt,
    input  logic       miss_evt,
    input  logic       btn_start,
    input  logic       btn_next,
    input  logic [2:0] gsm_state,
    input  logic [1:0] gsm_stage,
    input  logic [1:0] gsm_lives,
    input  logic [6:0] gsm_base_score,
    input  logic [6:0] gsm_timer,
    input  logic       gsm_done,
    output logic [3:0] flag,
    output logic       trig,
    output logic       busy,
    output logic       dropped_evt,
    output logic       timeout_err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_READY      = 3'b001;
    localparam logic [2:0] ST_PLAYING    = 3'b010;
    localparam logic [2:0] ST_OVER       = 3'b011;
    localparam logic [2:0] ST_STAGECLEAR = 3'b100;
    localparam logic [2:0] ST_GAMECLEAR  = 3'b101;

    localparam logic [3:0] CMD_HIT        = 4'b0001;
    localparam logic [3:0] CMD_MISS       = 4'b0010;
    localparam logic [3:0] CMD_NEXT_STAGE = 4'b1000;
    localparam logic [3:0] CMD_START      = 4'b1010;
    localparam logic [3:0] CMD_STAGE_CLR  = 4'b1100;
    localparam logic [3:0] CMD_GAME_OVER  = 4'b1101;
    localparam logic [3:0] CMD_GAME_CLR   = 4'b1110;
    localparam logic [3:0] CMD_RESTART    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } seq_state_e;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hit_pend_q, hit_pend_d;
    logic [1:0]       miss_pend_q, miss_pend_d;
    logic             start_req_q, start_req_d;
    logic             next_req_q, next_req_d;
    logic [3:0]       flag_q, flag_d;
    logic             trig_q, trig_d;
    logic             dropped_q, dropped_d;
    logic             timeout_q, timeout_d;

    logic       playing, ready, end_state;
    logic       sel_valid;
    logic [3:0] sel_cmd;
    logic       hit_dec, miss_dec, start_take, next_take;
    logic       hit_drop, miss_drop;

    assign playing   = (gsm_state == ST_PLAYING);
    assign ready     = (gsm_state == ST_READY);
    assign end_state = (gsm_state == ST_OVER) || (gsm_state == ST_STAGECLEAR) ||
                       (gsm_state == ST_GAMECLEAR);

    // Returns {drop, next}; a simultaneous increment and decrement leaves the count unchanged.
    function automatic logic [2:0] pendNext(input logic [1:0] cur, input logic inc,
                                            input logic dec, input logic active);
        logic [2:0] r;
        r = {1'b0, cur};
        if (!active) begin
            r = 3'b000;
        end else if (inc && !dec) begin
            r = (cur == 2'd3) ? {1'b1, cur} : {1'b0, cur + 2'd1};
        end else if (!inc && dec) begin
            r = {1'b0, cur - 2'd1};
        end
        return r;
    endfunction

    always_comb begin
        sel_valid  = 1'b0;
        sel_cmd    = flag_q;
        hit_dec    = 1'b0;
        miss_dec   = 1'b0;
        start_take = 1'b0;
        next_take  = 1'b0;
        if (state_q == IDLE) begin
            if (playing && gsm_lives == 2'd0) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_GAME_OVER;
            end else if (playing && gsm_base_score == 7'd0) begin
                sel_valid = 1'b1;
                sel_cmd   = (gsm_stage == MAX_STAGE) ? CMD_GAME_CLR : CMD_STAGE_CLR;
            end else if (playing && gsm_timer == 7'd0) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_GAME_OVER;
            end else if (playing && miss_pend_q != 2'd0) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_MISS;
                miss_dec  = 1'b1;
            end else if (playing && hit_pend_q != 2'd0) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_HIT;
                hit_dec   = 1'b1;
            end else if (ready && start_req_q) begin
                sel_valid  = 1'b1;
                sel_cmd    = CMD_START;
                start_take = 1'b1;
            end else if (next_req_q && gsm_state == ST_STAGECLEAR) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_NEXT_STAGE;
                next_take = 1'b1;
            end else if (next_req_q && (gsm_state == ST_OVER || gsm_state == ST_GAMECLEAR)) begin
                sel_valid = 1'b1;
                sel_cmd   = CMD_RESTART;
                next_take = 1'b1;
            end
        end
    end

    // Event capture keeps running while a command is in flight so bursts are not lost.
    always_comb begin
        {hit_drop, hit_pend_d}   = pendNext(hit_pend_q, hit_evt, hit_dec, playing);
        {miss_drop, miss_pend_d} = pendNext(miss_pend_q, miss_evt, miss_dec, playing);
        dropped_d = hit_drop | miss_drop;

        start_req_d = start_req_q;
        if (!ready) begin
            start_req_d = 1'b0;
        end else if (btn_start) begin
            start_req_d = 1'b1;
        end else if (start_take) begin
            start_req_d = 1'b0;
        end

        next_req_d = next_req_q;
        if (btn_next && end_state) begin
            next_req_d = 1'b1;
        end else if (next_take) begin
            next_req_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        trig_d    = trig_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    flag_d  = sel_cmd;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (gsm_done) begin
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    trig_d    = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                trig_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hit_pend_q  <= 2'd0;
            miss_pend_q <= 2'd0;
            start_req_q <= 1'b0;
            next_req_q  <= 1'b0;
            flag_q      <= 4'd0;
            trig_q      <= 1'b0;
            dropped_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_pend_q  <= hit_pend_d;
            miss_pend_q <= miss_pend_d;
            start_req_q <= start_req_d;
            next_req_q  <= next_req_d;
            flag_q      <= flag_d;
            trig_q      <= trig_d;
            dropped_q   <= dropped_d;
            timeout_q   <= timeout_d;
        end
    end

    assign flag        = flag_q;
    assign trig        = trig_q;
    assign busy        = (state_q != IDLE);
    assign dropped_evt = dropped_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_gsm_cmd_sequencer.sv
// Directed bench for gsm_cmd_sequencer: a small manager model answers commands, and a
// scoreboard of expected command codes is checked at every trig rise.
`timescale 1ns/1ps
module tb_gsm_cmd_sequencer;

    logic       clk_1mhz = 1'b0;
    logic       rst;
    logic       hit_evt, miss_evt, btn_start, btn_next;
    logic [2:0] gsm_state;
    logic [1:0] gsm_stage, gsm_lives;
    logic [6:0] gsm_base_score, gsm_timer;
    logic       gsm_done;
    logic [3:0] flag;
    logic       trig, busy, dropped_evt, timeout_err;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] sbq[$];
    int doneDelay = 3;
    int waitCnt   = 0;
    int highCnt   = 0;
    int lastHigh  = 0;
    int lowCnt    = 0;
    int dropCount = 0;
    bit trigPrev  = 1'b0;
    bit haveFall  = 1'b0;

    gsm_cmd_sequencer dut (
        .clk_1mhz      (clk_1mhz),
        .rst           (rst),
        .hit_evt       (hit_evt),
        .miss_evt      (miss_evt),
        .btn_start     (btn_start),
        .btn_next      (btn_next),
        .gsm_state     (gsm_state),
        .gsm_stage     (gsm_stage),
        .gsm_lives     (gsm_lives),
        .gsm_base_score(gsm_base_score),
        .gsm_timer     (gsm_timer),
        .gsm_done      (gsm_done),
        .flag          (flag),
        .trig          (trig),
        .busy          (busy),
        .dropped_evt   (dropped_evt),
        .timeout_err   (timeout_err)
    );

    always #500 clk_1mhz = ~clk_1mhz;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic hit, input logic miss, input logic start,
                                 input logic nxt);
        hit_evt   = hit;
        miss_evt  = miss;
        btn_start = start;
        btn_next  = nxt;
    endtask

    // One clock: pulses end, the command monitor runs and the manager model answers.
    task automatic tick();
        @(posedge clk_1mhz);
        @(negedge clk_1mhz);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        gsm_done = 1'b0;
        if (dropped_evt === 1'b1) dropCount++;
        if (rst) begin
            haveFall = 1'b0;
            trigPrev = trig;
        end else begin
            if (trig === 1'b1 && !trigPrev) begin
                compared++;
                assert (sbq.size() > 0)
                else begin
                    mismatched++;
                    $error("FAIL unexpected_cmd: observed flag %b, expected no command", flag);
                end
                if (sbq.size() > 0) checkOutput("cmd_flag", flag, sbq.pop_front());
                if (haveFall) checkOutput("trig_low_gap_ge3", lowCnt >= 3, 1);
                highCnt = 1;
                waitCnt = 0;
            end else if (trig === 1'b1) begin
                highCnt++;
                waitCnt++;
            end else if (trigPrev) begin
                lastHigh = highCnt;
                haveFall = 1'b1;
                lowCnt   = 1;
            end else begin
                lowCnt++;
            end
            if (trig === 1'b1 && doneDelay > 0 && waitCnt == doneDelay) begin
                gsm_done = 1'b1;
                case (flag)
                    4'b0001: if (gsm_base_score > 0) gsm_base_score = gsm_base_score - 7'd1;
                    4'b0010: if (gsm_lives > 0) gsm_lives = gsm_lives - 2'd1;
                    4'b1010: gsm_state = 3'b010;
                    4'b1100: gsm_state = 3'b100;
                    4'b1110: gsm_state = 3'b101;
                    4'b1101: gsm_state = 3'b011;
                    4'b1000: begin gsm_stage = gsm_stage + 2'd1; gsm_state = 3'b010; end
                    4'b1111: gsm_state = 3'b001;
                    default: ;
                endcase
            end
            trigPrev = trig;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitTrig(input logic level, input int limit, input string tag);
        int n = 0;
        while (trig !== level && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, trig, level);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        gsm_done       = 1'b0;
        gsm_state      = 3'b001;
        gsm_stage      = 2'd1;
        gsm_lives      = 2'd3;
        gsm_base_score = 7'd30;
        gsm_timer      = 7'd60;
        runCycles(2);
        checkOutput("rst_flag", flag, 4'd0);
        checkOutput("rst_trig", trig, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_dropped", dropped_evt, 1'b0);
        checkOutput("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] test 1: start command and handshake timing");
        doneDelay = 3;
        sbq.push_back(4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runCycles(2);
        checkOutput("t1_trig_rise", trig, 1'b1);
        checkOutput("t1_flag", flag, 4'b1010);
        checkOutput("t1_busy_rise", busy, 1'b1);
        runCycles(4);
        checkOutput("t1_trig_fall", trig, 1'b0);
        checkOutput("t1_flag_held", flag, 4'b1010);
        runCycles(2);
        checkOutput("t1_busy_settle", busy, 1'b1);
        tick();
        checkOutput("t1_busy_fall", busy, 1'b0);
        runCycles(5);

        $display("[TB] test 2: hit burst with saturation");
        gsm_state = 3'b001;
        tick();
        doneDelay = 8;
        sbq.push_back(4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitTrig(1'b1, 20, "t2_start_trig");
        gsm_state = 3'b010;
        dropCount = 0;
        for (int i = 0; i < 3; i++) sbq.push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        runCycles(80);
        checkOutput("t2_drop_count", dropCount, 2);
        checkOutput("t2_sb_empty", sbq.size(), 0);

        $display("[TB] test 3: stage clear and game clear");
        doneDelay = 3;
        gsm_base_score = 7'd1;
        gsm_stage = 2'd1;
        sbq.push_back(4'b0001);
        sbq.push_back(4'b1100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(40);
        checkOutput("t3a_sb_empty", sbq.size(), 0);
        gsm_state = 3'b010;
        gsm_base_score = 7'd1;
        gsm_stage = 2'd3;
        sbq.push_back(4'b0001);
        sbq.push_back(4'b1110);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(40);
        checkOutput("t3b_sb_empty", sbq.size(), 0);
        gsm_state = 3'b010;
        gsm_base_score = 7'd5;
        gsm_stage = 2'd1;
        runCycles(20);
        checkOutput("t3_pending_hit_cleared", busy, 1'b0);

        $display("[TB] test 4: miss before hit, then game over");
        gsm_lives = 2'd1;
        sbq.push_back(4'b0010);
        sbq.push_back(4'b1101);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        runCycles(40);
        checkOutput("t4_sb_empty", sbq.size(), 0);
        sbq.push_back(4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        runCycles(20);
        checkOutput("t4_restart_sb_empty", sbq.size(), 0);

        $display("[TB] test 5: done withheld");
        gsm_state = 3'b010;
        gsm_lives = 2'd3;
        gsm_base_score = 7'd5;
        doneDelay = 0;
        sbq.push_back(4'b0001);
        sbq.push_back(4'b0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        waitTrig(1'b1, 20, "t5_trig_rise");
        waitTrig(1'b0, 300, "t5_trig_fall");
        checkOutput("t5_high_len", lastHigh, 255);
        checkOutput("t5_timeout_set", timeout_err, 1'b1);
        doneDelay = 3;
        runCycles(30);
        checkOutput("t5_timeout_sticky", timeout_err, 1'b1);
        checkOutput("t5_sb_empty", sbq.size(), 0);

        $display("[TB] test 6: reset while trig high");
        doneDelay = 0;
        sbq.push_back(4'b0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        waitTrig(1'b1, 20, "t6_trig_rise");
        runCycles(5);
        rst = 1'b1;
        tick();
        checkOutput("t6_trig", trig, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_flag", flag, 4'd0);
        checkOutput("t6_timeout_clr", timeout_err, 1'b0);
        rst = 1'b0;
        doneDelay = 3;
        runCycles(40);
        checkOutput("t6_sb_empty", sbq.size(), 0);
        checkOutput("t6_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gsm_cmd_sequencer.md
Name: gsm_cmd_sequencer

Overview:
Upstream command issuer for the game state manager. It captures player and button events, applies the game rules against the manager's current state outputs, and issues one 4-bit command at a time over the flag/trig/done handshake. It serialises bursts of events so none are lost while a command is in flight, and it recovers if the manager never answers.

Parameters:
SETTLE_CYCLES, 3, cycles trig is held low after each command before the next one may be issued (minimum 2)
TIMEOUT_CYCLES, 255, maximum cycles trig stays high waiting for gsm_done
MAX_STAGE, 2'd3, final stage; clearing it ends the game with a win

Ports:
clk_1mhz  in  1  system clock, 1 MHz
rst  in  1  synchronous reset, active-high
hit_evt  in  1  one-cycle pulse: mole hit
miss_evt  in  1  one-cycle pulse: mole missed or wrong hit
btn_start  in  1  one-cycle pulse: start button
btn_next  in  1  one-cycle pulse: continue/restart button
gsm_state  in  3  manager state: 001 ready, 010 playing, 011 over, 100 stage clear, 101 game clear
gsm_stage  in  2  current stage
gsm_lives  in  2  current lives
gsm_base_score  in  7  hits remaining in the current stage
gsm_timer  in  7  seconds remaining
gsm_done  in  1  one-cycle command-complete pulse
flag  out  4  command code
trig  out  1  command trigger level
busy  out  1  high from the ISSUE state through the end of SETTLE
dropped_evt  out  1  one-cycle pulse when an event is discarded because its counter is saturated
timeout_err  out  1  sticky; set when a command times out

Behaviour:
- Reset:
  - Reset values: flag=0, trig=0, busy=0, dropped_evt=0, timeout_err=0.
  - All pending counters and requests are cleared; FSM goes to IDLE.
  - A reset mid-ISSUE drops trig on the next edge. The command in flight is abandoned.
- Event capture runs every cycle, in every FSM state:
  - hit_pend and miss_pend are 2-bit saturating counters. They increment only while gsm_state=010.
  - An event arriving at count 3 is discarded, and dropped_evt pulses.
  - If the same counter increments and decrements in one cycle, the net change is 0.
  - start_req is set by btn_start only while gsm_state=001.
  - next_req is set by btn_next only while gsm_state is 011, 100 or 101.
  - Events that arrive in any other state are ignored silently.
  - Whenever gsm_state≠010, hit_pend and miss_pend are cleared.
  - Whenever gsm_state≠001, start_req is cleared.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE selects at most one command per cycle, in this priority order. The first match wins.
  1. Playing, gsm_lives=0: issue 1101 (game over).
  2. Playing, gsm_base_score=0: issue 1110 if gsm_stage=MAX_STAGE, else 1100.
  3. Playing, gsm_timer=0: issue 1101.
  4. Playing, miss_pend>0: issue 0010 and decrement miss_pend.
  5. Playing, hit_pend>0: issue 0001 and decrement hit_pend.
  6. Ready, start_req: issue 1010 and clear start_req.
  7. next_req, taken from one of the following states; next_req is cleared:
     - stage clear (100): issue 1000.
     - over (011) or game clear (101): issue 1111.
- Issuing:
  - On selection, flag is registered and trig=1 on the next edge; the FSM enters ISSUE.
  - busy rises on that same edge.
  - flag stays stable from the trig rise until the next selection; between commands it holds its last value.
- ISSUE:
  - On gsm_done=1: trig=0 on the next edge, the wait counter is cleared, and the FSM enters SETTLE.
  - If the wait counter reaches TIMEOUT_CYCLES without gsm_done: trig=0, timeout_err=1, and the FSM enters SETTLE. The command is not retried.
  - A gsm_done pulse outside ISSUE is ignored.
- SETTLE:
  - trig stays low for exactly SETTLE_CYCLES cycles, then the FSM returns to IDLE.
  - busy falls on the edge that enters IDLE.
  - The manager outputs therefore reflect the completed command before the next rule evaluation. Example: a hit that drives base_score to 0 is followed by a stage-clear command.
- Back-to-back commands: the minimum trig-low gap is SETTLE_CYCLES. Two commands never share one trig high phase.

Test Plan:
1. State 001, btn_start pulse at cycle 0, bench model answers with gsm_done 3 cycles after trig rises -> flag=1010 and trig=1 at cycle 2; trig=0 the edge after done; busy=0 after 3 SETTLE cycles.
2. State 010, lives=3, base=30, 5 hit_evt pulses on consecutive cycles -> exactly three 0001 commands, each separated by ≥3 low cycles; dropped_evt pulses for the 4th and 5th hits.
3. State 010, base_score model goes to 0 after a 0001 command -> next command 1100 at stage 1; at stage 3 -> 1110; a pending hit is cleared once state leaves 010.
4. State 010, lives=1, hit_evt and miss_evt in the same cycle -> 0010 issued first; after lives=0, 1101 issued and no 0001 issued.
5. gsm_done withheld -> trig falls 255 cycles after rising, timeout_err=1 and stays 1; the next pending event is still issued afterwards.
6. rst asserted while trig=1 -> trig=0, busy=0 and flag=0 the next edge; an event pending before reset is never issued.
